// File: rtl/udp_tx_pkg.sv
`timescale 1ns/1ps
// udp_tx_pkg: shared types and field widths for the UDP transmit feeder.
package udp_tx_pkg;

    localparam int UDP_HDR_LEN = 8;
    localparam int PORT_W      = 16;
    localparam int LEN_W       = 12;
    localparam int FIELD_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GO,
        WAIT_RQ,
        STREAM
    } udp_tx_state_t;

    // 16-bit one's-complement addition with end-around carry
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/udp_csum_acc.sv
`timescale 1ns/1ps
// udp_csum_acc: running 16-bit one's-complement sum of payload words.
module udp_csum_acc
    import udp_tx_pkg::*;
(
    input  logic        mii_tx_clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        add_en,
    input  logic [15:0] add_word,
    output logic [15:0] sum
);

    // Accumulate one word per accepted byte; cleared once the frame sum is consumed
    always_ff @(posedge mii_tx_clk or posedge rst) begin
        if (rst) begin
            sum <= 16'h0000;
        end else if (clr) begin
            sum <= 16'h0000;
        end else if (add_en) begin
            sum <= ones_add(sum, add_word);
        end
    end

endmodule

// File: rtl/udp_tx_feeder.sv
`timescale 1ns/1ps
// udp_tx_feeder: buffers one UDP payload, then serves the UDP header and payload
// as a low-nibble-first stream to the IP transmit stage on request.
// Build option UDP_CSUM_EN: adds src_ip/dst_ip inputs and computes the UDP
// checksum; without it the checksum field is sent as zero.
module udp_tx_feeder
    import udp_tx_pkg::*;
#(
    parameter int MAX_PAYLOAD = 64
) (
    input  logic              mii_tx_clk,
    input  logic              rst,
`ifdef UDP_CSUM_EN
    input  logic [31:0]       src_ip,
    input  logic [31:0]       dst_ip,
`endif
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    input  logic [PORT_W-1:0] src_port,
    input  logic [PORT_W-1:0] dst_port,
    output logic              tx_go,
    output logic [LEN_W-1:0]  data_len,
    input  logic              fifo_rq,
    output logic [3:0]        fifo_da,
    output logic              busy,
    output logic              err_ovf
);

    localparam int PTR_W = $clog2(MAX_PAYLOAD + 1);
    localparam int AW    = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int NIB_W = LEN_W + 1;
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(MAX_PAYLOAD);
    localparam logic [NIB_W-1:0] NIB_MAX  = '1;

    udp_tx_state_t      state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [NIB_W-1:0]   nib_q;
    logic [7:0]         pay_mem [0:(2**AW)-1];
    logic [PORT_W-1:0]  src_port_q, dst_port_q;
    logic [FIELD_W-1:0] csum_field;
    logic [FIELD_W-1:0] len_field;
    logic               accept, room, store, commit;
    logic [LEN_W-1:0]   commit_len;
    logic [LEN_W-1:0]   byte_idx;
    logic [AW-1:0]      pay_idx;
    logic [7:0]         byte_sel;

    assign room       = (wr_ptr_q != PTR_FULL);
    assign accept     = wr_en & wr_ready;
    assign store      = accept & room;
    assign commit     = accept & wr_last;
    // A dropped final byte still commits, with the count clamped at the buffer size
    assign commit_len = LEN_W'(UDP_HDR_LEN)
                      + (room ? (LEN_W'(wr_ptr_q) + LEN_W'(1)) : LEN_W'(MAX_PAYLOAD));
    assign len_field  = {{(FIELD_W-LEN_W){1'b0}}, data_len};

    // State register
    always_ff @(posedge mii_tx_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded handshake outputs
    always_comb begin
        state_d  = state_q;
        wr_ready = 1'b0;
        tx_go    = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                wr_ready = ~rst;
                if (wr_en) begin
                    state_d = wr_last ? GO : LOAD;
                end
            end
            LOAD: begin
                wr_ready = ~rst;
                if (wr_en && wr_last) begin
                    state_d = GO;
                end
            end
            GO: begin
                tx_go   = 1'b1;
                busy    = 1'b1;
                state_d = WAIT_RQ;
            end
            WAIT_RQ: begin
                busy = 1'b1;
                if (fifo_rq) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                busy = 1'b1;
                if (!fifo_rq) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write pointer, commit capture, overflow pulse and nibble index
    always_ff @(posedge mii_tx_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            nib_q      <= '0;
            err_ovf    <= 1'b0;
            data_len   <= '0;
            src_port_q <= '0;
            dst_port_q <= '0;
        end else begin
            err_ovf <= accept & ~room;
            if (state_q == STREAM && !fifo_rq) begin
                wr_ptr_q <= '0;
            end else if (store) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (commit) begin
                data_len   <= commit_len;
                src_port_q <= src_port;
                dst_port_q <= dst_port;
            end
            // Index saturates rather than wrapping if the request is held very long
            if (!fifo_rq) begin
                nib_q <= '0;
            end else if (nib_q != NIB_MAX) begin
                nib_q <= nib_q + NIB_W'(1);
            end
        end
    end

    // Payload buffer; contents need no reset, only the pointer does
    always_ff @(posedge mii_tx_clk) begin
        if (store) begin
            pay_mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign byte_idx = nib_q[NIB_W-1:1];
    assign pay_idx  = AW'(byte_idx - LEN_W'(UDP_HDR_LEN));

    // Byte at the current stream position: big-endian header fields, payload, then zero padding
    always_comb begin
        byte_sel = 8'h00;
        if (byte_idx < data_len) begin
            case (byte_idx)
                LEN_W'(0): byte_sel = src_port_q[15:8];
                LEN_W'(1): byte_sel = src_port_q[7:0];
                LEN_W'(2): byte_sel = dst_port_q[15:8];
                LEN_W'(3): byte_sel = dst_port_q[7:0];
                LEN_W'(4): byte_sel = len_field[15:8];
                LEN_W'(5): byte_sel = len_field[7:0];
                LEN_W'(6): byte_sel = csum_field[15:8];
                LEN_W'(7): byte_sel = csum_field[7:0];
                default:   byte_sel = pay_mem[pay_idx];
            endcase
        end
    end

    // Registered nibble output, low nibble of each byte first
    always_ff @(posedge mii_tx_clk or posedge rst) begin
        if (rst) begin
            fifo_da <= 4'h0;
        end else begin
            fifo_da <= nib_q[0] ? byte_sel[7:4] : byte_sel[3:0];
        end
    end

`ifdef UDP_CSUM_EN
    logic [31:0] src_ip_q, dst_ip_q;
    logic [15:0] acc_sum, hdr_sum, csum_q, csum_inv;
    logic [15:0] acc_word;
    logic        acc_clr;

    // Even payload offsets are the high byte of a 16-bit word, odd ones the low byte
    assign acc_word = wr_ptr_q[0] ? {8'h00, wr_data} : {wr_data, 8'h00};
    assign acc_clr  = (state_q == WAIT_RQ);

    udp_csum_acc u_csum_acc (
        .mii_tx_clk (mii_tx_clk),
        .rst        (rst),
        .clr        (acc_clr),
        .add_en     (store),
        .add_word   (acc_word),
        .sum        (acc_sum)
    );

    // Fold pseudo-header and UDP header words (checksum field as zero) into the payload sum
    always_comb begin
        hdr_sum  = acc_sum;
        hdr_sum  = ones_add(hdr_sum, src_ip_q[31:16]);
        hdr_sum  = ones_add(hdr_sum, src_ip_q[15:0]);
        hdr_sum  = ones_add(hdr_sum, dst_ip_q[31:16]);
        hdr_sum  = ones_add(hdr_sum, dst_ip_q[15:0]);
        hdr_sum  = ones_add(hdr_sum, 16'd17);
        hdr_sum  = ones_add(hdr_sum, len_field);
        hdr_sum  = ones_add(hdr_sum, src_port_q);
        hdr_sum  = ones_add(hdr_sum, dst_port_q);
        hdr_sum  = ones_add(hdr_sum, len_field);
        csum_inv = ~hdr_sum;
    end

    // Capture IP addresses at commit; finalise the checksum in GO (zero goes out as 0xFFFF)
    always_ff @(posedge mii_tx_clk or posedge rst) begin
        if (rst) begin
            src_ip_q <= '0;
            dst_ip_q <= '0;
            csum_q   <= '0;
        end else begin
            if (commit) begin
                src_ip_q <= src_ip;
                dst_ip_q <= dst_ip;
            end
            if (state_q == GO) begin
                csum_q <= (csum_inv == 16'h0000) ? 16'hFFFF : csum_inv;
            end
        end
    end

    assign csum_field = csum_q;
`else
    assign csum_field = 16'h0000;
`endif

endmodule

// File: tb/tb_udp_tx_feeder.sv
`timescale 1ns/1ps
// tb_udp_tx_feeder: randomized frames driven into two feeders (large and tiny buffer)
// in parallel, each stream compared with a byte-level reference of the UDP frame.
module tb_udp_tx_feeder;

    localparam int MAXA = 64;
    localparam int MAXB = 4;

    logic        mii_tx_clk = 1'b0;
    logic        rst        = 1'b1;
    logic        wr_en      = 1'b0;
    logic [7:0]  wr_data    = 8'h00;
    logic        wr_last    = 1'b0;
    logic [15:0] src_port   = 16'h0000;
    logic [15:0] dst_port   = 16'h0000;
    logic        fifo_rq    = 1'b0;
`ifdef UDP_CSUM_EN
    logic [31:0] src_ip     = 32'h0;
    logic [31:0] dst_ip     = 32'h0;
`endif

    logic        a_wr_ready, a_tx_go, a_busy, a_err_ovf;
    logic [11:0] a_data_len;
    logic [3:0]  a_fifo_da;
    logic        b_wr_ready, b_tx_go, b_busy, b_err_ovf;
    logic [11:0] b_data_len;
    logic [3:0]  b_fifo_da;

    int checks = 0;
    int errors = 0;
    int go_a, go_b, ovf_a, ovf_b;

    logic [15:0] m_src, m_dst;
    logic [31:0] m_sip, m_dip;
    logic [7:0]  pay[$];

    always #20 mii_tx_clk = ~mii_tx_clk;

    udp_tx_feeder #(.MAX_PAYLOAD(MAXA)) ua (
        .mii_tx_clk (mii_tx_clk),
        .rst        (rst),
`ifdef UDP_CSUM_EN
        .src_ip     (src_ip),
        .dst_ip     (dst_ip),
`endif
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .wr_ready   (a_wr_ready),
        .src_port   (src_port),
        .dst_port   (dst_port),
        .tx_go      (a_tx_go),
        .data_len   (a_data_len),
        .fifo_rq    (fifo_rq),
        .fifo_da    (a_fifo_da),
        .busy       (a_busy),
        .err_ovf    (a_err_ovf)
    );

    udp_tx_feeder #(.MAX_PAYLOAD(MAXB)) ub (
        .mii_tx_clk (mii_tx_clk),
        .rst        (rst),
`ifdef UDP_CSUM_EN
        .src_ip     (src_ip),
        .dst_ip     (dst_ip),
`endif
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .wr_ready   (b_wr_ready),
        .src_port   (src_port),
        .dst_port   (dst_port),
        .tx_go      (b_tx_go),
        .data_len   (b_data_len),
        .fifo_rq    (fifo_rq),
        .fifo_da    (b_fifo_da),
        .busy       (b_busy),
        .err_ovf    (b_err_ovf)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock; outputs are observed on the falling edge and pulses tallied
    task automatic tick();
        @(negedge mii_tx_clk);
        go_a  += a_tx_go   ? 1 : 0;
        go_b  += b_tx_go   ? 1 : 0;
        ovf_a += a_err_ovf ? 1 : 0;
        ovf_b += b_err_ovf ? 1 : 0;
    endtask

    // ---------------- reference model ----------------
    function automatic int stored(input int maxp);
        return (pay.size() < maxp) ? pay.size() : maxp;
    endfunction

    function automatic logic [15:0] exp_csum(input int maxp);
`ifdef UDP_CSUM_EN
        logic [31:0] s;
        int          len;
        len = 8 + stored(maxp);
        s = m_sip[31:16] + m_sip[15:0] + m_dip[31:16] + m_dip[15:0] + 17
          + 2 * len + m_src + m_dst;
        for (int i = 0; i < stored(maxp); i++)
            s += (i % 2 == 0) ? (32'(pay[i]) << 8) : 32'(pay[i]);
        while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        s = ~s;
        return (s[15:0] == 16'h0000) ? 16'hFFFF : s[15:0];
`else
        return (maxp < 0) ? 16'hFFFF : 16'h0000;
`endif
    endfunction

    function automatic logic [7:0] exp_byte(input int maxp, input int k);
        int          len;
        logic [15:0] cs;
        len = 8 + stored(maxp);
        cs  = exp_csum(maxp);
        if (k >= len) return 8'h00;
        case (k)
            0: return m_src[15:8];
            1: return m_src[7:0];
            2: return m_dst[15:8];
            3: return m_dst[7:0];
            4: return 8'(len >> 8);
            5: return 8'(len & 255);
            6: return cs[15:8];
            7: return cs[7:0];
            default: return pay[k-8];
        endcase
    endfunction

    function automatic logic [3:0] exp_nib(input int maxp, input int idx);
        logic [7:0] b;
        b = exp_byte(maxp, idx / 2);
        return (idx % 2 == 1) ? b[7:4] : b[3:0];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic fill_pay(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    task automatic check_reset_vals();
        check_val("rst_wr_ready_a", a_wr_ready, 0);
        check_val("rst_wr_ready_b", b_wr_ready, 0);
        check_val("rst_tx_go_a",    a_tx_go,    0);
        check_val("rst_tx_go_b",    b_tx_go,    0);
        check_val("rst_busy_a",     a_busy,     0);
        check_val("rst_busy_b",     b_busy,     0);
        check_val("rst_err_ovf_a",  a_err_ovf,  0);
        check_val("rst_err_ovf_b",  b_err_ovf,  0);
        check_val("rst_fifo_da_a",  a_fifo_da,  0);
        check_val("rst_fifo_da_b",  b_fifo_da,  0);
        check_val("rst_data_len_a", a_data_len, 0);
        check_val("rst_data_len_b", b_data_len, 0);
    endtask

    // mode 0: full stream, 1: request dropped early, 2: reset asserted mid-stream
    task automatic run_frame(input bit gaps, input bit junk, input int mode);
        int ca, cb, nib_a, nib_b, nlen;
        ca    = stored(MAXA);
        cb    = stored(MAXB);
        nib_a = 2 * (8 + ca);
        nib_b = 2 * (8 + cb);
        go_a = 0; go_b = 0; ovf_a = 0; ovf_b = 0;
        src_port = m_src;
        dst_port = m_dst;
`ifdef UDP_CSUM_EN
        src_ip = m_sip;
        dst_ip = m_dip;
`endif
        for (int i = 0; i < pay.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    wr_en = 1'b0;
                    tick();
                end
            end
            wr_en   = 1'b1;
            wr_data = pay[i];
            wr_last = (i == pay.size() - 1);
            tick();
        end
        wr_en   = 1'b0;
        wr_last = 1'b0;
        // Ports change after commit; the frame must keep the committed values
        src_port = 16'($urandom);
        dst_port = 16'($urandom);
`ifdef UDP_CSUM_EN
        src_ip = $urandom;
        dst_ip = $urandom;
`endif
        check_val("busy_commit_a", a_busy, 1);
        check_val("busy_commit_b", b_busy, 1);
        for (int i = 0; i < 3; i++) begin
            if (junk) begin
                wr_en   = 1'b1;
                wr_data = 8'($urandom);
                wr_last = 1'($urandom);
            end
            tick();
        end
        wr_en   = 1'b0;
        wr_last = 1'b0;
        check_val("tx_go_cnt_a", go_a, 1);
        check_val("tx_go_cnt_b", go_b, 1);
        check_val("ovf_cnt_a", ovf_a, (pay.size() > MAXA) ? pay.size() - MAXA : 0);
        check_val("ovf_cnt_b", ovf_b, (pay.size() > MAXB) ? pay.size() - MAXB : 0);
        check_val("data_len_a", a_data_len, 8 + ca);
        check_val("data_len_b", b_data_len, 8 + cb);
        check_val("wr_ready_wait_a", a_wr_ready, 0);
        check_val("wr_ready_wait_b", b_wr_ready, 0);

        nlen = ((nib_a > nib_b) ? nib_a : nib_b) + 4;
        if (mode != 0) nlen = $urandom_range(1, nib_b - 1);
        fifo_rq = 1'b1;
        for (int k = 1; k <= nlen; k++) begin
            tick();
            check_val($sformatf("nib_a[%0d]", k - 1), a_fifo_da, exp_nib(MAXA, k - 1));
            check_val($sformatf("nib_b[%0d]", k - 1), b_fifo_da, exp_nib(MAXB, k - 1));
        end

        if (mode == 2) begin
            rst = 1'b1;
            repeat (3) tick();
            check_reset_vals();
            rst     = 1'b0;
            fifo_rq = 1'b0;
            go_a = 0; go_b = 0;
            repeat (6) tick();
            check_val("post_rst_go_a", go_a, 0);
            check_val("post_rst_go_b", go_b, 0);
            check_val("post_rst_ready_a", a_wr_ready, 1);
            check_val("post_rst_busy_a", a_busy, 0);
        end else begin
            check_val("len_stable_a", a_data_len, 8 + ca);
            check_val("len_stable_b", b_data_len, 8 + cb);
            fifo_rq = 1'b0;
            tick();
            check_val("end_ready_a", a_wr_ready, 1);
            check_val("end_ready_b", b_wr_ready, 1);
            check_val("end_busy_a", a_busy, 0);
            check_val("end_busy_b", b_busy, 0);
            check_val("end_go_a", go_a, 1);
            check_val("end_go_b", go_b, 1);
        end
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        go_a = 0; go_b = 0; ovf_a = 0; ovf_b = 0;
        m_sip = 32'h0; m_dip = 32'h0;
        repeat (3) tick();
        check_reset_vals();
        rst = 1'b0;
        tick();
        check_val("ready_after_rst_a", a_wr_ready, 1);
        check_val("ready_after_rst_b", b_wr_ready, 1);

        // Known ports, 20-byte payload
        m_src = 16'h0521; m_dst = 16'h1527;
        fill_pay(20);
        run_frame(1'b0, 1'b0, 0);

        // Six bytes: overflows the 4-byte buffer twice
        m_src = 16'($urandom); m_dst = 16'($urandom);
        fill_pay(6);
        run_frame(1'b1, 1'b0, 0);

        // Single byte committing from IDLE, request dropped early
        pay.delete();
        pay.push_back(8'hA5);
        run_frame(1'b0, 1'b0, 1);

        // Writes offered while waiting for the request are ignored
        m_src = 16'($urandom); m_dst = 16'($urandom);
        fill_pay(9);
        run_frame(1'b0, 1'b1, 0);

        // Overflow of the large buffer
        fill_pay(MAXA + 2);
        run_frame(1'b0, 1'b0, 0);

        // Reset in the middle of loading discards the frame
        go_a = 0; go_b = 0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom); wr_last = 1'b0;
            tick();
        end
        wr_en = 1'b0;
        rst = 1'b1;
        tick();
        check_val("midload_rst_ready_a", a_wr_ready, 0);
        rst = 1'b0;
        repeat (5) tick();
        check_val("midload_go_a", go_a, 0);
        check_val("midload_go_b", go_b, 0);
        check_val("midload_ready_a", a_wr_ready, 1);

        // Reset in the middle of streaming
        m_src = 16'($urandom); m_dst = 16'($urandom);
        fill_pay(12);
        run_frame(1'b1, 1'b0, 2);

        // Randomized frames
        for (int f = 0; f < 10; f++) begin
            m_src = 16'($urandom); m_dst = 16'($urandom);
            m_sip = $urandom;      m_dip = $urandom;
            fill_pay($urandom_range(1, 24));
            run_frame(1'($urandom), 1'($urandom), $urandom_range(0, 1));
        end

`ifdef UDP_CSUM_EN
        begin
            logic [31:0] s;
            logic [15:0] w;
            m_sip = 32'hC0A80002; m_dip = 32'hC0A80003;
            m_src = 16'h0521;     m_dst = 16'h1527;
            pay.delete();
            pay.push_back(8'h48); pay.push_back(8'h65); pay.push_back(8'h6C);
            pay.push_back(8'h6C); pay.push_back(8'h6F);
            run_frame(1'b0, 1'b0, 0);

            // Two-byte payload chosen so the one's-complement sum is 0xFFFF
            s = m_sip[31:16] + m_sip[15:0] + m_dip[31:16] + m_dip[15:0] + 17 + 20
              + m_src + m_dst;
            while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
            w = 16'hFFFF - s[15:0];
            pay.delete();
            pay.push_back(w[15:8]);
            pay.push_back(w[7:0]);
            check_val("zero_sum_model", exp_csum(MAXA), 16'hFFFF);
            run_frame(1'b0, 1'b0, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
